// File: rtl/logic_basic_queue_control.sv
// Ready/valid queue controller driving an external registered-read memory plus a one-entry
// output stage. Define LOGIC_BASIC_QUEUE_CONTROL_LEVEL_EN to get a registered occupancy count.
module logic_basic_queue_control #(
  parameter int unsigned DATA_WIDTH    = 1,
  parameter int unsigned ADDRESS_WIDTH = 1
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  input  logic [DATA_WIDTH-1:0]    rx_tdata,
  output logic                     tx_tvalid,
  input  logic                     tx_tready,
  output logic [DATA_WIDTH-1:0]    tx_tdata,
  output logic                     write_enable,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [ADDRESS_WIDTH-1:0] write_pointer,
  output logic                     read_enable,
  output logic [ADDRESS_WIDTH-1:0] read_pointer,
  input  logic [DATA_WIDTH-1:0]    read_data,
  output logic [ADDRESS_WIDTH:0]   level
);

  localparam int unsigned PtrWidth = ADDRESS_WIDTH + 1;

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic                rx_tready_q, rx_tready_d;
  logic                tx_tvalid_q, tx_tvalid_d;
  logic                empty;
  logic                full_next;

  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    write_enable = rx_tvalid && rx_tready_q;
    // Refill the output stage whenever it is empty or being drained this cycle.
    read_enable  = !empty && (!tx_tvalid_q || tx_tready);

    wr_ptr_d = wr_ptr_q + {{ADDRESS_WIDTH{1'b0}}, write_enable};
    rd_ptr_d = rd_ptr_q + {{ADDRESS_WIDTH{1'b0}}, read_enable};

    full_next   = (wr_ptr_d[ADDRESS_WIDTH-1:0] == rd_ptr_d[ADDRESS_WIDTH-1:0]) &&
                  (wr_ptr_d[ADDRESS_WIDTH] != rd_ptr_d[ADDRESS_WIDTH]);
    rx_tready_d = !full_next;

    tx_tvalid_d = tx_tvalid_q;
    if (read_enable) begin
      tx_tvalid_d = 1'b1;
    end else if (tx_tready) begin
      tx_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_tready_q <= 1'b0;
      tx_tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rx_tready_q <= rx_tready_d;
      tx_tvalid_q <= tx_tvalid_d;
    end
  end

  assign rx_tready     = rx_tready_q;
  assign tx_tvalid     = tx_tvalid_q;
  assign tx_tdata      = read_data;
  assign write_data    = rx_tdata;
  assign write_pointer = wr_ptr_q[ADDRESS_WIDTH-1:0];
  assign read_pointer  = rd_ptr_q[ADDRESS_WIDTH-1:0];

`ifdef LOGIC_BASIC_QUEUE_CONTROL_LEVEL_EN
  logic [PtrWidth-1:0] level_q, level_d;

  // Memory occupancy plus the output stage, taken from next-state values so it stays registered.
  always_comb begin
    level_d = (wr_ptr_d - rd_ptr_d) + {{ADDRESS_WIDTH{1'b0}}, tx_tvalid_d};
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_logic_basic_queue_control.sv
// Directed bench for logic_basic_queue_control (DATA_WIDTH=8, ADDRESS_WIDTH=2, capacity 5)
// with a behavioural registered-read memory and a reference queue of accepted beats.
module tb_logic_basic_queue_control;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          rx_tvalid = 1'b0;
  logic          rx_tready;
  logic [DW-1:0] rx_tdata = '0;
  logic          tx_tvalid;
  logic          tx_tready = 1'b0;
  logic [DW-1:0] tx_tdata;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_pointer;
  logic          read_enable;
  logic [AW-1:0] read_pointer;
  logic [DW-1:0] read_data;
  logic [AW:0]   level;

  logic [DW-1:0] mem [4];

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  int lvl = 0;
  int total_wr = 0;
  int total_rd = 0;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (write_enable) mem[write_pointer] <= write_data;
    if (read_enable) read_data <= mem[read_pointer];
  end

  logic_basic_queue_control #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .write_enable(write_enable), .write_data(write_data), .write_pointer(write_pointer),
    .read_enable(read_enable), .read_pointer(read_pointer), .read_data(read_data),
    .level(level)
  );

  function automatic int exp_level();
`ifdef LOGIC_BASIC_QUEUE_CONTROL_LEVEL_EN
    return lvl;
`else
    return 0;
`endif
  endfunction

  // Called at posedge+1: samples handshakes at the negedge, advances one edge, updates the model.
  task automatic tick(output bit rx_hs, output bit tx_hs, output bit tx_v,
                      output logic [DW-1:0] tx_d, output logic [DW-1:0] tx_exp);
    logic [DW-1:0] rx_d;
    #4;
    rx_hs = rx_tvalid && rx_tready;
    tx_hs = tx_tvalid && tx_tready;
    tx_v  = tx_tvalid;
    tx_d  = tx_tdata;
    rx_d  = rx_tdata;
    @(posedge aclk);
    #1;
    tx_exp = 'x;
    if (rx_hs) begin exp_q.push_back(rx_d); lvl++; total_wr++; end
    if (tx_hs) begin
      lvl--; total_rd++;
      if (exp_q.size() > 0) tx_exp = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    tests_run++; if (rx_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_tready got=%b want=0", rx_tready); end
    tests_run++; if (tx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_tvalid got=%b want=0", tx_tvalid); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got=%0d want=0", level); end
    tests_run++; if (write_pointer !== 2'd0 || read_pointer !== 2'd0) begin tests_failed++; $display("FAIL reset_pointers got wr=%0d rd=%0d want 0/0", write_pointer, read_pointer); end
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    tests_run++; if (rx_tready !== 1'b1) begin tests_failed++; $display("FAIL release_rx_tready got=%b want=1", rx_tready); end
    tests_run++; if (tx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL release_tx_tvalid got=%b want=0", tx_tvalid); end
  endtask

  task automatic test_single_beat();
    bit rh, th, tv; logic [DW-1:0] td, te;
    tx_tready = 1'b1; rx_tvalid = 1'b1; rx_tdata = 8'hA5;
    tick(rh, th, tv, td, te);
    rx_tvalid = 1'b0;
    tests_run++; if (rh !== 1'b1) begin tests_failed++; $display("FAIL single_accept got=%b want=1", rh); end
    tests_run++; if (tx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL single_latency1 tx_tvalid got=%b want=0", tx_tvalid); end
    tests_run++; if (level !== 3'(exp_level())) begin tests_failed++; $display("FAIL single_level1 got=%0d want=%0d", level, exp_level()); end
    tick(rh, th, tv, td, te);
    tests_run++; if (tx_tvalid !== 1'b1 || tx_tdata !== 8'hA5) begin tests_failed++; $display("FAIL single_latency2 got valid=%b data=%h want 1/a5", tx_tvalid, tx_tdata); end
    tick(rh, th, tv, td, te);
    tests_run++; if (th !== 1'b1 || td !== 8'hA5) begin tests_failed++; $display("FAIL single_output got hs=%b data=%h want 1/a5", th, td); end
    tests_run++; if (tx_tvalid !== 1'b0) begin tests_failed++; $display("FAIL single_clear got=%b want=0", tx_tvalid); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL single_level_end got=%0d want=0", level); end
  endtask

  task automatic test_fill();
    bit rh, th, tv; logic [DW-1:0] td, te;
    int nxt = 1; int acc = 0;
    tx_tready = 1'b0; rx_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rx_tdata = 8'(nxt);
      tick(rh, th, tv, td, te);
      if (rh) begin
        acc++; nxt++;
        if (acc == 4) begin
          tests_run++; if (rx_tready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_after4 got=%b want=1", rx_tready); end
        end
        if (acc == 5) begin
          tests_run++; if (rx_tready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready_after5 got=%b want=0", rx_tready); end
        end
      end
    end
    tests_run++; if (acc !== 5) begin tests_failed++; $display("FAIL fill_accepted got=%0d want=5", acc); end
    tests_run++; if (rx_tready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready_held got=%b want=0", rx_tready); end
    tests_run++; if (level !== 3'(exp_level())) begin tests_failed++; $display("FAIL fill_level got=%0d want=%0d", level, exp_level()); end
    tests_run++; if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h01) begin tests_failed++; $display("FAIL fill_head got valid=%b data=%h want 1/01", tx_tvalid, tx_tdata); end
  endtask

  task automatic test_drain();
    bit rh, th, tv; logic [DW-1:0] td, te;
    int outs = 0;
    tx_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(rh, th, tv, td, te);
      if (rh) rx_tvalid = 1'b0;
      if (th) begin
        outs++;
        tests_run++; if (td !== te) begin tests_failed++; $display("FAIL drain_data beat=%0d got=%h want=%h", outs, td, te); end
      end
    end
    tests_run++; if (outs !== 6) begin tests_failed++; $display("FAIL drain_count got=%0d want=6", outs); end
    tests_run++; if (tx_tvalid !== 1'b0 || exp_q.size() != 0) begin tests_failed++; $display("FAIL drain_empty got valid=%b left=%0d want 0/0", tx_tvalid, exp_q.size()); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL drain_level got=%0d want=0", level); end
  endtask

  task automatic test_stream();
    bit rh, th, tv; logic [DW-1:0] td, te;
    int sent = 0; int got = 0; int first = -1; int last = -1; int stalls = 0;
    tx_tready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      rx_tvalid = (sent < 20);
      rx_tdata = 8'(8'h40 + sent);
      tick(rh, th, tv, td, te);
      if (rh) sent++;
      else if (sent < 20) stalls++;
      if (th) begin
        if (first < 0) first = c;
        last = c; got++;
        tests_run++; if (td !== te) begin tests_failed++; $display("FAIL stream_data beat=%0d got=%h want=%h", got, td, te); end
      end
    end
    rx_tvalid = 1'b0;
    tests_run++; if (got !== 20 || stalls !== 0) begin tests_failed++; $display("FAIL stream_count got out=%0d stalls=%0d want 20/0", got, stalls); end
    tests_run++; if (first !== 2 || last !== 21) begin tests_failed++; $display("FAIL stream_timing got first=%0d last=%0d want 2/21", first, last); end
    tests_run++; if (write_pointer !== 2'(total_wr % 4) || read_pointer !== 2'(total_rd % 4)) begin
      tests_failed++; $display("FAIL stream_wrap got wr=%0d rd=%0d want %0d/%0d", write_pointer, read_pointer, total_wr % 4, total_rd % 4);
    end
  endtask

  task automatic test_backpressure();
    bit rh, th, tv; logic [DW-1:0] td, te;
    int sent = 0; int got = 0;
    bit prev_stall = 1'b0; logic [DW-1:0] prev_d = '0;
    for (int c = 0; c < 1000 && got < 100; c++) begin
      rx_tvalid = (sent < 100);
      rx_tdata = 8'($urandom);
      tx_tready = 1'($urandom_range(0, 1));
      tick(rh, th, tv, td, te);
      if (rh) sent++;
      if (prev_stall) begin
        tests_run++; if (tv !== 1'b1 || td !== prev_d) begin tests_failed++; $display("FAIL bp_stable got valid=%b data=%h want 1/%h", tv, td, prev_d); end
      end
      if (th) begin
        got++;
        tests_run++; if (td !== te) begin tests_failed++; $display("FAIL bp_order beat=%0d got=%h want=%h", got, td, te); end
      end
      prev_stall = tv && !th;
      prev_d = td;
    end
    rx_tvalid = 1'b0; tx_tready = 1'b1;
    tests_run++; if (got !== 100 || exp_q.size() != 0) begin tests_failed++; $display("FAIL bp_count got out=%0d left=%0d want 100/0", got, exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    bit rh, th, tv; logic [DW-1:0] td, te;
    int got = 0;
    tx_tready = 1'b0; rx_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_tdata = 8'(8'h31 + i);
      tick(rh, th, tv, td, te);
    end
    rx_tvalid = 1'b0;
    tests_run++; if (level !== 3'(exp_level())) begin tests_failed++; $display("FAIL mid_level_before got=%0d want=%0d", level, exp_level()); end
    #2;
    areset_n = 1'b0;
    #1;
    tests_run++; if (tx_tvalid !== 1'b0 || rx_tready !== 1'b0) begin tests_failed++; $display("FAIL mid_async got valid=%b ready=%b want 0/0", tx_tvalid, rx_tready); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL mid_level got=%0d want=0", level); end
    exp_q.delete(); lvl = 0; total_wr = 0; total_rd = 0;
    repeat (2) @(posedge aclk);
    #1;
    areset_n = 1'b1;
    @(posedge aclk);
    #1;
    tests_run++; if (rx_tready !== 1'b1 || write_pointer !== 2'd0 || read_pointer !== 2'd0) begin
      tests_failed++; $display("FAIL mid_release got ready=%b wr=%0d rd=%0d want 1/0/0", rx_tready, write_pointer, read_pointer);
    end
    tx_tready = 1'b1; rx_tvalid = 1'b1; rx_tdata = 8'h77;
    tick(rh, th, tv, td, te);
    rx_tvalid = 1'b0;
    for (int c = 0; c < 5 && got == 0; c++) begin
      tick(rh, th, tv, td, te);
      if (th) begin
        got++;
        tests_run++; if (td !== 8'h77 || te !== 8'h77) begin tests_failed++; $display("FAIL mid_first got=%h want=77", td); end
      end
    end
    tests_run++; if (got !== 1) begin tests_failed++; $display("FAIL mid_timeout got out=%0d want=1", got); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill();
    test_drain();
    test_stream();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_basic_queue_control.md
LOGIC_BASIC_QUEUE_CONTROL -- requirements
Module: logic_basic_queue_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, meaning the payload width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 1, meaning the memory address width; memory depth is 2**ADDRESS_WIDTH.
REQ-003 SHALL have ports, in order:
- aclk  input  1  clock, all logic on its rising edge.
- areset_n  input  1  asynchronous active-low reset.
- rx_tvalid  input  1  upstream data valid.
- rx_tready  output  1  upstream ready.
- rx_tdata  input  DATA_WIDTH  upstream payload.
- tx_tvalid  output  1  downstream data valid.
- tx_tready  input  1  downstream ready.
- tx_tdata  output  DATA_WIDTH  downstream payload.
- write_enable  output  1  memory write strobe.
- write_data  output  DATA_WIDTH  memory write data.
- write_pointer  output  ADDRESS_WIDTH  memory write address.
- read_enable  output  1  memory read strobe.
- read_pointer  output  ADDRESS_WIDTH  memory read address.
- read_data  input  DATA_WIDTH  memory registered read data, one-cycle latency, held while read_enable=0.
- level  output  ADDRESS_WIDTH+1  entries held (see REQ-019).
REQ-004 SHALL use one clock, aclk; reset areset_n is asynchronous, active-low.

Function
REQ-005 SHALL keep write and read pointers of ADDRESS_WIDTH+1 bits; the MSB distinguishes full from empty; the low bits drive write_pointer and read_pointer.
REQ-006 SHALL treat the memory as empty when the pointers are equal, and as full when the low bits are equal and the MSBs differ.
REQ-007 SHALL assert write_enable = rx_tvalid && rx_tready; write_data = rx_tdata, combinationally.
REQ-008 SHALL increment the write pointer on write_enable, wrapping modulo 2**(ADDRESS_WIDTH+1).
REQ-009 SHALL register rx_tready; its next value is "not full" computed from the next-state pointers.
REQ-010 SHALL assert read_enable = !empty && (!tx_tvalid || tx_tready), combinationally, and increment the read pointer on read_enable.
REQ-011 SHALL set tx_tvalid on the clock edge where read_enable=1, and clear it on an edge where tx_tready=1 and read_enable=0.
REQ-012 SHALL drive tx_tdata = read_data directly; tx_tdata is stable while tx_tvalid=1 and tx_tready=0.
REQ-013 SHALL give total capacity 2**ADDRESS_WIDTH+1 (memory plus output stage).
REQ-014 SHALL give latency from an accepted rx beat on an empty block to tx_tvalid=1 of exactly 2 cycles.
REQ-015 SHALL, when full, accept simultaneous rx and tx transfers only after rx_tready re-rises; full gives no combinational bypass.
REQ-016 SHALL sustain one beat per cycle on both sides when neither full nor empty.
REQ-017 SHALL never read an unwritten entry; same-address read and write cannot coincide on occupied data.

Reset
REQ-018 SHALL, while areset_n=0, hold pointers at 0, rx_tready=0, tx_tvalid=0 and level=0; rx_tready SHALL be 1 on the first edge after release.

Configuration
REQ-019 SHALL, with macro LOGIC_BASIC_QUEUE_CONTROL_LEVEL_EN defined, drive level as a registered count of memory entries plus tx_tvalid, range 0..2**ADDRESS_WIDTH+1. Without the macro, level SHALL be tied to 0 and no counter is synthesized.

Structure
REQ-020 SHALL place no typedefs in a shared package; pointer widths are local parameters derived from ADDRESS_WIDTH.
REQ-021 SHALL contain no sub-module; its memory ports connect one-to-one to the team's logic_basic_queue_generic_memory in the parent.

Verification (DATA_WIDTH=8, ADDRESS_WIDTH=2, capacity 5)
REQ-022 Reset release, then one beat 0xA5 with tx_tready=1 -> tx_tvalid=1 with tx_tdata=0xA5 two cycles after acceptance; level (macro on) returns to 0.
REQ-023 tx_tready=0, push 0x01..0x06 continuously -> 5 accepted, rx_tready=0 on the edge after the 5th; level=5; 0x06 held upstream.
REQ-024 From full, tx_tready=1 for 8 cycles -> 0x01..0x05 output in order, then 0x06 after it is accepted; no duplicates or drops.
REQ-025 Streaming 20 beats with both sides always ready -> one beat per cycle after the 2-cycle fill, pointers wrap cleanly.
REQ-026 Random tx_tready backpressure on 100 beats -> tx_tdata stable while stalled; output order matches input order.
REQ-027 Assert areset_n=0 mid-stream with 3 entries -> tx_tvalid=0, rx_tready=0 immediately; after release the queue is empty and the next beat emerges first.
